// File: rtl/rx_serial_paralelo_pkg.sv
// Shared constants and types for the RX serial-to-parallel converter.
// Holds the FSM encodings, the K28.5 comma symbol and the counter widths.
package rx_sp_pkg;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [7:0] K28_5 = 8'hBC;

  localparam int CNT_W      = 3;
  localparam int SYNC_CNT_W = 3;

  // Default number of consecutive aligned commas needed for lock (2..7).
  localparam int SYNC_COMMAS_DEF = 4;

  typedef enum logic [1:0] {
    HUNT   = ST_HUNT,
    SYNC   = ST_SYNC,
    ACTIVE = ST_ACTIVE
  } rx_sp_state_e;

  function automatic logic is_comma(input logic [7:0] win);
    return (win == K28_5);
  endfunction

endpackage

// File: rtl/rx_serial_paralelo_if.sv
// Serial-in / byte-out bundle of the RX serial-to-parallel converter.
// master drives the serial bit and watches the byte side; slave is the converter.
interface rx_sp_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_stb,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_stb,
    output active
  );

endinterface

// File: rtl/rx_serial_paralelo_shifter.sv
// Serial shift register and 3-bit bit counter.
// Presents the 8-bit window {sr, data_in} and flags the byte boundary (cnt == 7).
// cnt_clr restarts the bit counter so the next boundary lands 8 edges later.
module rx_sp_shifter
  import rx_sp_pkg::*;
(
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       cnt_clr,
  output logic [7:0] w,
  output logic       boundary
);

  logic [6:0]       sr;
  logic [CNT_W-1:0] cnt;

  assign w        = {sr, data_in};
  assign boundary = &cnt;

  // Shift every edge; the counter free-runs unless the FSM re-phases it.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      sr  <= w[6:0];
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rx_serial_paralelo.sv
// RX serial-to-parallel converter with K28.5 comma alignment.
// Locks byte boundaries after SYNC_COMMAS consecutive aligned commas, then
// emits every aligned byte with a one-cycle strobe; commas are never valid.
// Optional macro RX_SP_REALIGN_EN: two misaligned commas in ACTIVE drop lock.
//
// state  | meaning
// HUNT   | searching every edge for a comma; bit counter free-running
// SYNC   | counting aligned commas at byte boundaries
// ACTIVE | locked; aligned bytes delivered at each boundary
module rx_serial_paralelo
  import rx_sp_pkg::*;
#(
  parameter int SYNC_COMMAS = SYNC_COMMAS_DEF
) (
  input  logic   clk_32f,
  input  logic   reset,
  rx_sp_if.slave bus
);

  localparam logic [SYNC_CNT_W-1:0] SYNC_TGT = SYNC_CNT_W'(SYNC_COMMAS);

  rx_sp_state_e          state, state_nxt;
  logic [SYNC_CNT_W-1:0] sync_cnt, sync_cnt_nxt, sync_cnt_inc;
  logic [7:0]            data_q, data_nxt;
  logic                  valid_q, valid_nxt;
  logic                  stb_q, stb_nxt;
  logic                  cnt_clr;
  logic [7:0]            win;
  logic                  boundary;
  logic                  comma;
`ifdef RX_SP_REALIGN_EN
  logic [1:0]            miss_cnt, miss_cnt_nxt;
`endif

  rx_sp_shifter u_shifter (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (bus.data_in),
    .cnt_clr  (cnt_clr),
    .w        (win),
    .boundary (boundary)
  );

  assign comma = is_comma(win);

  // Saturate at the lock target so the counter can never wrap.
  assign sync_cnt_inc = (sync_cnt >= SYNC_TGT) ? SYNC_TGT : sync_cnt + 1'b1;

  // State, lock counter and registered byte outputs.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      sync_cnt <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      stb_q    <= 1'b0;
`ifdef RX_SP_REALIGN_EN
      miss_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      sync_cnt <= sync_cnt_nxt;
      data_q   <= data_nxt;
      valid_q  <= valid_nxt;
      stb_q    <= stb_nxt;
`ifdef RX_SP_REALIGN_EN
      miss_cnt <= miss_cnt_nxt;
`endif
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    data_nxt     = data_q;
    valid_nxt    = valid_q;
    stb_nxt      = 1'b0;
    cnt_clr      = 1'b0;
`ifdef RX_SP_REALIGN_EN
    miss_cnt_nxt = miss_cnt;
`endif
    case (state)
      HUNT: begin
        valid_nxt = 1'b0;
        if (comma) begin
          // The comma's last bit sits at cnt == 7 of the new framing.
          cnt_clr      = 1'b1;
          sync_cnt_nxt = SYNC_CNT_W'(1);
          state_nxt    = SYNC;
        end
      end
      SYNC: begin
        valid_nxt = 1'b0;
        if (boundary) begin
          if (comma) begin
            sync_cnt_nxt = sync_cnt_inc;
            if (sync_cnt_inc == SYNC_TGT) state_nxt = ACTIVE;
          end else begin
            sync_cnt_nxt = '0;
            state_nxt    = HUNT;
          end
        end
      end
      ACTIVE: begin
`ifdef RX_SP_REALIGN_EN
        if (miss_cnt == 2'd2) begin
          // Clearing miss_cnt here keeps a later relock from dropping at once.
          state_nxt    = HUNT;
          valid_nxt    = 1'b0;
          sync_cnt_nxt = '0;
          miss_cnt_nxt = '0;
        end else begin
          if (boundary) begin
            data_nxt  = win;
            stb_nxt   = 1'b1;
            valid_nxt = !comma;
          end
          if (comma) miss_cnt_nxt = boundary ? 2'd0 : miss_cnt + 2'd1;
        end
`else
        if (boundary) begin
          data_nxt  = win;
          stb_nxt   = 1'b1;
          valid_nxt = !comma;
        end
`endif
      end
      default: begin
        state_nxt = HUNT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.byte_stb  = stb_q;
  assign bus.active    = (state == ACTIVE);

endmodule

// File: tb/tb_rx_serial_paralelo.sv
// Self-checking bench for rx_serial_paralelo.
// A byte-level reference model tracks lock (count of back-to-back commas)
// and the expected byte-side outputs; random payloads fill the locked phases.
module tb_rx_serial_paralelo;
  import rx_sp_pkg::*;

  localparam int SYNC_N = 4;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;

  rx_sp_if bus ();

  rx_serial_paralelo dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         m_locked = 1'b0;
  int         m_run    = 0;
  logic [7:0] m_data   = 8'h00;
  logic       m_valid  = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  bit         chk_en   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic model_reset();
    m_locked  = 1'b0;
    m_run     = 0;
    m_data    = 8'h00;
    m_valid   = 1'b0;
    prev_byte = 8'h00;
  endtask

  // Send one byte MSB first and compare the byte side against the model.
  task automatic send_byte(input logic [7:0] b);
    bit was_locked;
    was_locked = m_locked;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i == 7 && chk_en) begin
        chk("stb_low", bus.byte_stb, 1'b0);
        chk("data_hold", bus.data_out, m_data);
        chk("valid_hold", bus.valid_out, m_valid);
      end
    end
    if (chk_en) begin
      if (was_locked) begin
        m_data  = b;
        m_valid = (b != K28_5);
      end else begin
        m_valid = 1'b0;
      end
      if (!m_locked) begin
        if (b == K28_5) begin
          m_run++;
          if (m_run >= SYNC_N) m_locked = 1'b1;
        end else begin
          m_run = 0;
        end
      end
      chk("active", bus.active, m_locked);
      chk("byte_stb", bus.byte_stb, was_locked);
      chk("data_out", bus.data_out, m_data);
      chk("valid_out", bus.valid_out, m_valid);
    end
    prev_byte = b;
  endtask

  // True if a comma appears at any non-byte-aligned offset across a->b.
  function automatic bit misaligned(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] s;
    s = {a, b};
    for (int k = 1; k < 8; k++)
      if (s[15-k -: 8] == K28_5) return 1'b1;
    return 1'b0;
  endfunction

  // Random payload that never forms a stray comma with its predecessor.
  function automatic logic [7:0] pick_payload(input logic [7:0] prev);
    logic [7:0] cand;
    if ($urandom_range(0, 7) == 0) return K28_5;
    for (int t = 0; t < 20; t++) begin
      cand = 8'($urandom_range(0, 255));
      if (cand != K28_5 && !misaligned(prev, cand)) return cand;
    end
    return K28_5;
  endfunction

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_byte(pick_payload(prev_byte));
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(K28_5);
  endtask

  // Assert reset between edges, check outputs clear at once, hold 3 cycles.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_stb", bus.byte_stb, 1'b0);
    chk("rst_active", bus.active, 1'b0);
    repeat (3) @(posedge clk_32f);
    #1;
    chk("rst_hold_active", bus.active, 1'b0);
    @(negedge clk_32f);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    chk("init_data", bus.data_out, 8'h00);
    chk("init_active", bus.active, 1'b0);
    @(negedge clk_32f);
    reset = 1'b1;
    model_reset();

    // Lock on four commas, then fixed payload.
    send_commas(4);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'hF0);
    send_byte(K28_5);
    send_random(12);

    // Reset mid-byte while locked, then lock behind 3 random lead bits.
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    send_commas(4);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'hF0);
    send_byte(K28_5);
    send_random(8);

    // Aborted sync attempt, then a successful one.
    do_reset();
    send_commas(3);
    send_byte(8'hAC);
    chk("abort_active", bus.active, 1'b0);
    send_commas(4);
    send_byte(8'hDB);
    chk("db_valid", bus.valid_out, 1'b1);

    // Comma interleaved with payload while locked.
    send_byte(8'h29);
    send_byte(K28_5);
    chk("comma_valid", bus.valid_out, 1'b0);
    send_byte(8'hA8);
    send_random(10);

    // One-bit slip followed by two commas at the new phase.
    send_byte(8'h29);
    chk_en = 1'b0;
    send_bit(1'b0);
    send_commas(2);
    send_bit(1'b0);
    send_bit(1'b0);
`ifdef RX_SP_REALIGN_EN
    chk("slip_active", bus.active, 1'b0);
    chk("slip_valid", bus.valid_out, 1'b0);
    // The last capture before the drop is the comma seen one bit early.
    chk("slip_data", bus.data_out, 8'h5E);
    model_reset();
    m_data = 8'h5E;
    chk_en = 1'b1;
    send_commas(4);
    send_byte(8'hDB);
    send_random(6);
`else
    chk("slip_active", bus.active, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_serial_paralelo.md
# rx_serial_paralelo

Serial-to-parallel converter with comma alignment for the RX path. It takes the recovered 1-bit serial stream at clk_32f and locks byte boundaries on the K28.5 comma (8'hBC). It then delivers aligned bytes with a valid flag, framed for the RX byte demux that feeds the four lane outputs. Comma bytes are never flagged valid.

## Interface
- COMMA, 8'hBC: alignment/idle symbol.
- SYNC_COMMAS, 4: consecutive aligned commas required to declare lock (range 2..7).
- clk_32f  in  1  serial bit clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); one clock, no other clock domain.
- data_in  in  1  serial bit, MSB of each byte first, sampled on posedge clk_32f.
- data_out  out  8  last completed aligned byte (registered).
- valid_out  out  1  data_out is a payload byte (ACTIVE and byte != COMMA).
- byte_stb  out  1  one-cycle pulse per completed aligned byte in ACTIVE.
- active  out  1  lock achieved (state == ACTIVE).

## Operation
- Window w = {sr[6:0], data_in}; sr shifts left every cycle, data_in into LSB.
- 3-bit bit counter cnt; byte boundary when cnt == 7 on the sampling edge, then cnt wraps to 0.
- States:
  - HUNT: cnt is free-running. On any edge with w == COMMA: cnt <= 0, sync_cnt <= 1, go to SYNC.
  - SYNC: at each boundary, if w == COMMA, sync_cnt++. When sync_cnt reaches SYNC_COMMAS, go to ACTIVE. A non-comma at a boundary gives sync_cnt <= 0 and a return to HUNT. Off-boundary windows are ignored.
  - ACTIVE: at each boundary, data_out <= w, byte_stb <= 1, valid_out <= (w != COMMA). ACTIVE is left only by reset, or by the realign feature when it is compiled in.
- sync_cnt is 3 bits and saturates; it never wraps past SYNC_COMMAS.
- Outside ACTIVE, data_out holds its value, valid_out = 0, byte_stb = 0.
- Reset (asynchronous, any cycle, including mid-byte or in ACTIVE) clears:
  - state to HUNT
  - sr, cnt, sync_cnt, miss_cnt to 0
  - data_out to 8'h00
  - valid_out, byte_stb, active to 0
- Operation resumes on the first posedge after reset deasserts.

## Timing
- Latency: data_out/valid_out/byte_stb change on the edge that samples the 8th bit. They are visible for the following cycle.
- data_out/valid_out hold for 8 cycles, until the next boundary. byte_stb is high for exactly 1 cycle.
- First comma is detected on the edge sampling its last bit. The next boundary is 8 edges later.
- Lock:
  - active rises on the edge sampling the last bit of the SYNC_COMMAS-th comma.
  - The first valid byte appears 8 edges later at the earliest.
- Comma and boundary on the same edge in ACTIVE: byte captured, valid_out = 0, byte_stb = 1.

## Configuration
- RX_SP_REALIGN_EN defined:
  - In ACTIVE, w == COMMA at a non-boundary edge increments a 2-bit miss_cnt.
  - An aligned COMMA clears miss_cnt.
  - At miss_cnt == 2: state <= HUNT, active <= 0, valid_out <= 0, sync_cnt <= 0, cnt free-running.
- Not defined: no miss_cnt. Misaligned commas are ignored; ACTIVE is exited only by reset.

## Structure
- Package rx_sp_pkg:
  - State encodings localparam ST_HUNT = 2'd0, ST_SYNC = 2'd1, ST_ACTIVE = 2'd2.
  - K28_5 = 8'hBC.
  - Width constants for cnt (3) and sync_cnt (3).
- Sub-module rx_sp_shifter holds sr, cnt and the w/boundary outputs, with cnt clear input. The top holds the FSM and output registers.

## Test plan
- Reset release, then 4×BC, then 8'h10, 8'h02, 8'hF0 MSB-first: active rises at 4th BC last bit; then data_out = 10, 02, F0 with valid_out = 1, byte_stb pulses every 8 cycles.
- Stream with 3 random bits before the first BC: lock occurs with boundary aligned to the comma; bytes are correct as above.
- 3×BC, then 8'hAC, then 4×BC, then 8'hDB: first attempt returns to HUNT at AC (active = 0); second locks; DB is output valid.
- In ACTIVE, interleave BC between 8'h29 and 8'hA8: BC byte gives byte_stb = 1, valid_out = 0, data_out = BC; the neighbours are valid.
- Assert reset for 3 cycles mid-byte in ACTIVE: all outputs 0 immediately (asynchronous); relock needs 4 fresh BCs.
- RX_SP_REALIGN_EN: in ACTIVE, insert a 1-bit slip then BC BC: active falls after the 2nd misaligned BC, valid_out = 0; relock on new alignment. Without the macro: active stays 1.
